// File: rtl/neo_rtc_pkg.sv
// neo_rtc_pkg: shared command codes, modes, time layout and calendar helpers for the uPD4990A model
package neo_rtc_pkg;
    localparam logic [3:0] CMD_HOLD  = 4'h0;
    localparam logic [3:0] CMD_SHIFT = 4'h1;
    localparam logic [3:0] CMD_SET   = 4'h2;
    localparam logic [3:0] CMD_READ  = 4'h3;
    localparam logic [3:0] CMD_TP64  = 4'h4;
    localparam logic [3:0] CMD_TP256 = 4'h5;
    localparam logic [3:0] CMD_TP2K  = 4'h6;
    localparam logic [3:0] CMD_TP4K  = 4'h7;
    localparam logic [3:0] CMD_INT1  = 4'h8;
    localparam logic [3:0] CMD_INT10 = 4'h9;
    localparam logic [3:0] CMD_INT30 = 4'hA;
    localparam logic [3:0] CMD_INT60 = 4'hB;
    localparam logic [3:0] CMD_ICLR  = 4'hC;
    localparam logic [3:0] CMD_IRUN  = 4'hD;
    localparam logic [3:0] CMD_ISTOP = 4'hE;
    localparam logic [3:0] CMD_TEST  = 4'hF;

    typedef enum logic {MODE_HOLD, MODE_SHIFT} mode_t;
    typedef enum logic [2:0] {TP_64, TP_256, TP_2K, TP_4K, TP_I1, TP_I10, TP_I30, TP_I60} tp_sel_t;

    localparam int SEC_LO  = 0;
    localparam int MIN_LO  = 8;
    localparam int HOUR_LO = 16;
    localparam int DAY_LO  = 24;
    localparam int WDAY_LO = 32;
    localparam int MON_LO  = 36;
    localparam int YEAR_LO = 40;

    localparam logic [47:0] TIME_RESET = 48'h00_1_0_01_00_00_00;

    function automatic logic [7:0] bcd_inc(input logic [7:0] x);
        return x[3:0] == 4'h9 ? {x[7:4] + 4'd1, 4'h0} : x + 8'd1;
    endfunction

    // 10 = 2 mod 4, so BCD year mod 4 is (2*tens + ones) mod 4
    function automatic logic [7:0] days_in_month(input logic [3:0] mon, input logic [7:0] year);
        logic [4:0] m4;
        m4 = {year[7:4], 1'b0} + {1'b0, year[3:0]};
        return mon == 4'd2 ? (m4[1:0] == 2'd0 ? 8'h29 : 8'h28) :
               (mon == 4'd4 || mon == 4'd6 || mon == 4'd9 || mon == 4'd11) ? 8'h30 : 8'h31;
    endfunction
endpackage

// File: rtl/neo_rtc_bcd_cal.sv
// neo_rtc_bcd_cal: BCD time/calendar register with single-cycle carry chain
module neo_rtc_bcd_cal
    import neo_rtc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        tick,
    input  logic [47:0] load_val,
    output logic [47:0] value
);
    logic [7:0] sec, mins, hour, day, year;
    logic [3:0] wday, mon;
    logic       c_min, c_hour, c_day, c_mon, c_year;
    logic [47:0] nxt;

    assign {year, mon, wday, day, hour, mins, sec} = value;
    assign c_min  = sec == 8'h59;
    assign c_hour = c_min && mins == 8'h59;
    assign c_day  = c_hour && hour == 8'h23;
    assign c_mon  = c_day && day == days_in_month(mon, year);
    assign c_year = c_mon && mon == 4'd12;

    // out-of-range values fall through to plain increment until they hit a compare
    assign nxt = {
        c_year ? (year == 8'h99 ? 8'h00 : bcd_inc(year)) : year,
        c_mon  ? (mon == 4'd12 ? 4'd1 : mon + 4'd1) : mon,
        c_day  ? (wday == 4'd6 ? 4'd0 : wday + 4'd1) : wday,
        c_day  ? (c_mon ? 8'h01 : bcd_inc(day)) : day,
        c_hour ? (c_day ? 8'h00 : bcd_inc(hour)) : hour,
        c_min  ? (c_hour ? 8'h00 : bcd_inc(mins)) : mins,
        c_min  ? 8'h00 : bcd_inc(sec)
    };

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) value <= TIME_RESET;
        else if (load) value <= load_val;
        else if (tick) value <= nxt;
endmodule

// File: rtl/neo_rtc_4990.sv
// neo_rtc_4990: uPD4990A serial calendar/clock model driven by the NEO-F0 RTC pins
// Serial pins are synchronized into CLK; time is seeded by the host via TIME_LOAD.
module neo_rtc_4990
    import neo_rtc_pkg::*;
#(
    parameter int CLK_HZ = 24000000
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        RTC_DIN,
    input  logic        RTC_CLK,
    input  logic        RTC_STROBE,
    output logic        RTC_DOUT,
    output logic        RTC_TP,
    input  logic [47:0] TIME_INIT,
    input  logic        TIME_LOAD,
    output logic [47:0] TIME_NOW
);
    logic [1:0]  din_s;
    logic [2:0]  clk_s, stb_s;
    logic        clk_rise, stb_rise, set_exec, clr, tick, sec_tick;
    logic [3:0]  cmd, cmd_sh, tp_bit;
    logic [47:0] sreg, sreg_sh;
    mode_t       mode;
    tp_sel_t     tp_sel;
    logic        hold, irun, tp_q;
    logic [5:0]  icnt, ilen;
    logic [31:0] acc, acc_sum;
    logic [12:0] div;

    assign clk_rise = clk_s[1] & ~clk_s[2];
    assign stb_rise = stb_s[1] & ~stb_s[2];
    assign cmd_sh   = clk_rise ? {din_s[1], cmd[3:1]} : cmd;
    assign sreg_sh  = (clk_rise && mode == MODE_SHIFT) ? {cmd[0], sreg[47:1]} : sreg;
    assign set_exec = stb_rise && cmd_sh == CMD_SET;
    assign clr      = TIME_LOAD | set_exec;
    assign acc_sum  = acc + 32'd8192;
    assign tick     = acc_sum >= 32'(CLK_HZ);
    assign sec_tick = tick && &div && !clr;
    assign ilen     = tp_sel == TP_I1 ? 6'd1 : tp_sel == TP_I10 ? 6'd10 : tp_sel == TP_I30 ? 6'd30 : 6'd60;
    assign tp_bit   = tp_sel == TP_64 ? 4'd6 : tp_sel == TP_256 ? 4'd4 : tp_sel == TP_2K ? 4'd1 : 4'd0;
    assign RTC_TP   = tp_sel >= TP_I1 ? tp_q : ~div[tp_bit];
    assign RTC_DOUT = mode == MODE_SHIFT ? sreg[0] : div[12];

    always_ff @(posedge CLK or negedge nRESET)
        if (!nRESET) begin
            din_s <= '0;
            clk_s <= '0;
            stb_s <= '0;
        end else begin
            din_s <= {din_s[0], RTC_DIN};
            clk_s <= {clk_s[1:0], RTC_CLK};
            stb_s <= {stb_s[1:0], RTC_STROBE};
        end

    // fractional accumulator: one tick per CLK_HZ/8192 clocks on average
    always_ff @(posedge CLK or negedge nRESET)
        if (!nRESET) begin
            acc <= '0;
            div <= '0;
        end else if (clr) begin
            acc <= '0;
            div <= '0;
        end else if (tick) begin
            acc <= acc_sum - 32'(CLK_HZ);
            div <= div + 13'd1;
        end else
            acc <= acc_sum;

    always_ff @(posedge CLK or negedge nRESET)
        if (!nRESET) begin
            cmd    <= '0;
            sreg   <= '0;
            mode   <= MODE_HOLD;
            hold   <= 1'b0;
            tp_sel <= TP_64;
            irun   <= 1'b0;
            tp_q   <= 1'b1;
            icnt   <= '0;
        end else begin
            cmd  <= cmd_sh;
            sreg <= sreg_sh;
            if (sec_tick && irun) begin
                icnt <= icnt + 6'd1 >= ilen ? 6'd0 : icnt + 6'd1;
                if (icnt + 6'd1 >= ilen) tp_q <= ~tp_q;
            end
            // strobe sees the post-shift command and overrides same-cycle updates
            if (stb_rise)
                case (cmd_sh)
                    CMD_HOLD:  begin mode <= MODE_HOLD;  hold <= 1'b0; end
                    CMD_SHIFT: begin mode <= MODE_SHIFT; hold <= 1'b0; end
                    CMD_SET:   begin mode <= MODE_HOLD;  hold <= 1'b1; end
                    CMD_READ:  begin sreg <= TIME_NOW; mode <= MODE_HOLD; hold <= 1'b0; end
                    CMD_ICLR:  begin icnt <= '0; tp_q <= 1'b1; end
                    CMD_IRUN:  irun <= 1'b1;
                    CMD_ISTOP: irun <= 1'b0;
                    default:   if (cmd_sh[3] ^ cmd_sh[2]) tp_sel <= tp_sel_t'({cmd_sh[3], cmd_sh[1:0]});
                endcase
        end

    neo_rtc_bcd_cal u_cal (
        .clk      (CLK),
        .rst_n    (nRESET),
        .load     (clr),
        .tick     (sec_tick & ~hold),
        .load_val (TIME_LOAD ? TIME_INIT : sreg_sh),
        .value    (TIME_NOW)
    );
endmodule

// File: tb/tb_neo_rtc_4990.sv
// tb_neo_rtc_4990: directed + randomized checks of the uPD4990A model against a calendar reference
module tb_neo_rtc_4990;
    localparam int CLK_HZ = 8320;
    localparam logic [47:0] RST_TIME = 48'h00_1_0_01_00_00_00;

    logic        clk = 0, nreset = 1, din = 0, sclk = 0, stb = 0, tl = 0;
    logic [47:0] tinit = '0, tnow, v, rd;
    logic        dout, tp;
    int          n_cmp = 0, n_bad = 0, c, p;

    always #5 clk = ~clk;

    neo_rtc_4990 #(.CLK_HZ(CLK_HZ)) dut (
        .CLK(clk), .nRESET(nreset), .RTC_DIN(din), .RTC_CLK(sclk), .RTC_STROBE(stb),
        .RTC_DOUT(dout), .RTC_TP(tp), .TIME_INIT(tinit), .TIME_LOAD(tl), .TIME_NOW(tnow)
    );

    function automatic int b2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int x);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int mdays(input int mo, input int y);
        if (mo == 2) return (y % 4 == 0) ? 29 : 28;
        return (mo == 4 || mo == 6 || mo == 9 || mo == 11) ? 30 : 31;
    endfunction

    function automatic logic [47:0] mk(input int y, input int mo, input int wd, input int d, input int h, input int mi, input int s);
        return {i2b(y), 4'(mo), 4'(wd), i2b(d), i2b(h), i2b(mi), i2b(s)};
    endfunction

    // calendar reference: decode to integers, add one second, re-encode
    function automatic logic [47:0] next_sec(input logic [47:0] t);
        int s, mi, h, d, wd, mo, y;
        s = b2i(t[7:0]); mi = b2i(t[15:8]); h = b2i(t[23:16]); d = b2i(t[31:24]);
        wd = int'(t[35:32]); mo = int'(t[39:36]); y = b2i(t[47:40]);
        s++;
        if (s == 60) begin s = 0; mi++; end
        if (mi == 60) begin mi = 0; h++; end
        if (h == 24) begin h = 0; d++; wd = (wd + 1) % 7; end
        if (d > mdays(mo, y)) begin d = 1; mo++; end
        if (mo > 12) begin mo = 1; y = (y + 1) % 100; end
        return mk(y, mo, wd, d, h, mi, s);
    endfunction

    function automatic logic [47:0] rand_time();
        int y, mo, d;
        y = int'($urandom_range(99));
        mo = int'($urandom_range(12, 1));
        d = $urandom_range(1) != 0 ? mdays(mo, y) : int'($urandom_range(mdays(mo, y), 1));
        return mk(y, mo, int'($urandom_range(6)), d,
                  $urandom_range(1) != 0 ? 23 : int'($urandom_range(23)),
                  $urandom_range(1) != 0 ? 59 : int'($urandom_range(59)),
                  $urandom_range(3) != 0 ? 59 : int'($urandom_range(59)));
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int num, input int den);
        n_cmp++;
        assert (obs * den - num <= den && num - obs * den <= den) else begin
            n_bad++;
            $error("FAIL %s: got %0d cycles expected %0d/%0d +-1", tag, obs, num, den);
        end
    endtask

    task automatic ser_bit(input logic b);
        din = b;
        repeat (4) @(negedge clk);
        sclk = 1;
        repeat (4) @(negedge clk);
        sclk = 0;
    endtask

    task automatic send_cmd(input logic [3:0] cd);
        for (int i = 0; i < 4; i++) ser_bit(cd[i]);
        repeat (4) @(negedge clk);
        stb = 1;
        repeat (4) @(negedge clk);
        stb = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic read48(output logic [47:0] r);
        send_cmd(4'h3);
        send_cmd(4'h1);
        for (int i = 0; i < 48; i++) begin
            r[i] = dout;
            ser_bit(1'b0);
        end
    endtask

    task automatic tload(input logic [47:0] t);
        @(negedge clk);
        tinit = t;
        tl = 1;
        @(negedge clk);
        tl = 0;
    endtask

    task automatic wait_tp(input logic lvl, output int cyc);
        logic prev;
        prev = tp;
        cyc = 0;
        while (cyc <= CLK_HZ + 200) begin
            @(negedge clk);
            cyc++;
            if (tp === lvl && prev !== lvl) break;
            prev = tp;
        end
        n_cmp++;
        assert (cyc <= CLK_HZ + 200) else begin
            n_bad++;
            $error("FAIL tp_edge_timeout: waited %0d cycles for TP edge to %b", cyc, lvl);
        end
    endtask

    initial begin
        #2 nreset = 0;
        repeat (3) @(negedge clk);
        chk("rst_time", tnow, RST_TIME);
        chk("rst_tp", 48'(tp), 48'd1);
        chk("rst_dout", 48'(dout), 48'd0);
        nreset = 1;
        repeat (4) @(negedge clk);

        read48(rd);
        chk("read_rst", rd, RST_TIME);
        chk("read_rst_day", 48'(rd[31:24]), 48'h01);

        v = mk(99, 12, 6, 31, 23, 59, 59);
        for (int i = 0; i < 48; i++) ser_bit(v[i]);
        send_cmd(4'h2);
        chk("set_load", tnow, v);
        send_cmd(4'h0);
        repeat (CLK_HZ) @(negedge clk);
        chk("set_rollover", tnow, next_sec(v));
        chk("set_rollover_abs", tnow, RST_TIME);
        read48(rd);
        chk("read_after_roll", rd, next_sec(v));

        v = mk(24, 2, 3, 28, 23, 59, 59);
        tload(v);
        chk("load_leap", tnow, v);
        repeat (CLK_HZ + 100) @(negedge clk);
        chk("leap_feb29", tnow, next_sec(v));
        v = mk(23, 2, 3, 28, 23, 59, 59);
        tload(v);
        repeat (CLK_HZ + 100) @(negedge clk);
        chk("nonleap_mar01", tnow, next_sec(v));

        for (int k = 4; k < 8; k++) begin
            send_cmd(4'(k));
            wait_tp(1'b1, c);
            wait_tp(1'b1, p);
            chk_tol($sformatf("tp_period_cmd%0d", k), p, CLK_HZ, 64 << (k == 4 ? 0 : k == 5 ? 2 : k == 6 ? 5 : 6));
        end

        send_cmd(4'h8);
        send_cmd(4'hC);
        chk("iclr_tp_high", 48'(tp), 48'd1);
        send_cmd(4'hD);
        wait_tp(1'b0, c);
        wait_tp(1'b1, p);
        chk_tol("interval_1s_rise", p, CLK_HZ, 1);
        wait_tp(1'b0, p);
        chk_tol("interval_1s_fall", p, CLK_HZ, 1);
        send_cmd(4'hE);
        for (int k = 0; k < 3; k++) begin
            v = rand_time();
            tload(v);
            chk("rand_load", tnow, v);
            repeat (CLK_HZ + 100) @(negedge clk);
            chk("rand_tick", tnow, next_sec(v));
            chk("tp_frozen", 48'(tp), 48'd0);
        end
        send_cmd(4'hC);
        chk("iclr_after_stop", 48'(tp), 48'd1);

        for (int i = 0; i < 10; i++) ser_bit(1'($urandom_range(1)));
        din = 1;
        repeat (4) @(negedge clk);
        sclk = 1;
        repeat (2) @(negedge clk);
        nreset = 0;
        @(negedge clk);
        chk("midrst_time", tnow, RST_TIME);
        chk("midrst_tp", 48'(tp), 48'd1);
        chk("midrst_dout", 48'(dout), 48'd0);
        sclk = 0;
        din = 0;
        repeat (4) @(negedge clk);
        nreset = 1;
        repeat (4) @(negedge clk);
        read48(rd);
        chk("read_after_midrst", rd, RST_TIME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
